// File: rtl/cache_level_if.sv
// Request/response channel of one cache level: valid/ready request in, single-cycle response pulse out.
interface cache_level_if #(
    parameter int ADDR_W = 48
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_op;
    logic              resp_valid;
    logic              resp_hit;
    logic              resp_err;
    logic              resp_evict;
    logic              resp_wb;
    logic [ADDR_W-1:0] resp_evict_addr;

    modport master (
        output req_valid, req_addr, req_op,
        input  req_ready, resp_valid, resp_hit, resp_err, resp_evict, resp_wb, resp_evict_addr
    );

    modport slave (
        input  req_valid, req_addr, req_op,
        output req_ready, resp_valid, resp_hit, resp_err, resp_evict, resp_wb, resp_evict_addr
    );
endinterface

// File: rtl/cache_level.sv
// One set-associative cache level: 3-cycle lookup/update per request, FIFO or LRU victim choice,
// write-through or write-back, saturating statistics and eviction/writeback reporting.
module cache_level #(
    parameter int ADDR_W      = 48,
    parameter int NUM_SETS    = 16,
    parameter int ASSOC       = 4,
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             replace_policy,
    input  logic             write_policy,
    cache_level_if.slave     bus,
    output logic [CNT_W-1:0] reads,
    output logic [CNT_W-1:0] writes,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] mem_writes
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int AGE_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ASSOC - 1);
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_UPDATE = 2'd2} state_t;

    state_t r_state, w_next;

    logic             r_valid [NUM_SETS][ASSOC];
    logic             r_dirty [NUM_SETS][ASSOC];
    logic [TAG_W-1:0] r_tag   [NUM_SETS][ASSOC];
    logic [AGE_W-1:0] r_age   [NUM_SETS][ASSOC];

    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_req_tag;
    logic             r_is_read, r_is_write, r_lru, r_wb;
    logic             r_hit, r_vic_valid, r_vic_dirty;
    logic [AGE_W-1:0] r_way, r_old_age;
    logic [TAG_W-1:0] r_vic_tag;

    logic              r_resp_valid, r_resp_hit, r_resp_err, r_resp_evict, r_resp_wb;
    logic [ADDR_W-1:0] r_resp_evict_addr;
    logic [CNT_W-1:0]  r_reads, r_writes, r_hits, r_misses, r_mem_writes;

    logic              w_hit, w_inv_found;
    logic [AGE_W-1:0]  w_hit_way, w_inv_way, w_max_way, w_max_age, w_vic_way, w_way;
    logic [AGE_W-1:0]  w_new_age [ASSOC];
    logic [ADDR_W-1:0] w_evict_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state decode
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = bus.req_valid ? S_LOOKUP : S_IDLE;
            S_LOOKUP: w_next = S_UPDATE;
            S_UPDATE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Tag compare and victim search over the captured set
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_max_way   = '0;
        w_max_age   = '0;
        for (int w = 0; w < ASSOC; w++) begin
            w_hit_way   = (r_valid[r_idx][w] && (r_tag[r_idx][w] == r_req_tag)) ? AGE_W'(w) : w_hit_way;
            w_hit       = w_hit | (r_valid[r_idx][w] && (r_tag[r_idx][w] == r_req_tag));
            w_inv_way   = (!r_valid[r_idx][w] && !w_inv_found) ? AGE_W'(w) : w_inv_way;
            w_inv_found = w_inv_found | !r_valid[r_idx][w];
            w_max_way   = (r_age[r_idx][w] > w_max_age) ? AGE_W'(w) : w_max_way;
            w_max_age   = (r_age[r_idx][w] > w_max_age) ? r_age[r_idx][w] : w_max_age;
        end
        w_vic_way = w_inv_found ? w_inv_way : w_max_way;
        w_way     = w_hit ? w_hit_way : w_vic_way;
    end

    // Ages after touching r_way: it becomes youngest, younger valid ways age by one
    always_comb begin
        for (int w = 0; w < ASSOC; w++) begin
            w_new_age[w] = (AGE_W'(w) == r_way) ? '0 :
                           (r_valid[r_idx][w] && (r_age[r_idx][w] < r_old_age)) ? r_age[r_idx][w] + AGE_W'(1) :
                           r_age[r_idx][w];
        end
        w_evict_addr = ADDR_W'({r_vic_tag, r_idx}) << OFF_W;
    end

    // State, line arrays, lookup results, response and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_age[s][w]   <= '0;
                end
            end
            r_idx             <= '0;
            r_req_tag         <= '0;
            r_is_read         <= 1'b0;
            r_is_write        <= 1'b0;
            r_lru             <= 1'b0;
            r_wb              <= 1'b0;
            r_hit             <= 1'b0;
            r_way             <= '0;
            r_old_age         <= '0;
            r_vic_valid       <= 1'b0;
            r_vic_dirty       <= 1'b0;
            r_vic_tag         <= '0;
            r_resp_valid      <= 1'b0;
            r_resp_hit        <= 1'b0;
            r_resp_err        <= 1'b0;
            r_resp_evict      <= 1'b0;
            r_resp_wb         <= 1'b0;
            r_resp_evict_addr <= '0;
            r_reads           <= '0;
            r_writes          <= '0;
            r_hits            <= '0;
            r_misses          <= '0;
            r_mem_writes      <= '0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_idx      <= bus.req_addr[OFF_W +: IDX_W];
                        r_req_tag  <= bus.req_addr[ADDR_W-1 -: TAG_W];
                        r_is_read  <= (bus.req_op == OP_R);
                        r_is_write <= (bus.req_op == OP_W);
                        r_lru      <= replace_policy;
                        r_wb       <= write_policy;
                    end
                end
                S_LOOKUP: begin
                    r_hit       <= w_hit;
                    r_way       <= w_way;
                    // An invalid fill behaves as if the oldest line were replaced
                    r_old_age   <= w_hit ? r_age[r_idx][w_hit_way] :
                                   (r_valid[r_idx][w_vic_way] ? r_age[r_idx][w_vic_way] : AGE_MAX);
                    r_vic_valid <= !w_hit && r_valid[r_idx][w_vic_way];
                    r_vic_dirty <= r_dirty[r_idx][w_vic_way];
                    r_vic_tag   <= r_tag[r_idx][w_vic_way];
                end
                S_UPDATE: begin
                    r_resp_valid <= 1'b1;
                    if (!(r_is_read || r_is_write)) begin
                        r_resp_err        <= 1'b1;
                        r_resp_hit        <= 1'b0;
                        r_resp_evict      <= 1'b0;
                        r_resp_wb         <= 1'b0;
                        r_resp_evict_addr <= '0;
                    end else begin
                        r_resp_err        <= 1'b0;
                        r_resp_hit        <= r_hit;
                        r_resp_evict      <= r_vic_valid;
                        r_resp_wb         <= r_vic_valid && r_vic_dirty && r_wb;
                        r_resp_evict_addr <= r_vic_valid ? w_evict_addr : '0;
                        if (r_hit) begin
                            if (r_is_write && r_wb) begin
                                r_dirty[r_idx][r_way] <= 1'b1;
                            end
                        end else begin
                            r_valid[r_idx][r_way] <= 1'b1;
                            r_tag[r_idx][r_way]   <= r_req_tag;
                            r_dirty[r_idx][r_way] <= r_wb && r_is_write;
                        end
                        if (r_lru || !r_hit) begin
                            for (int w = 0; w < ASSOC; w++) begin
                                r_age[r_idx][w] <= w_new_age[w];
                            end
                        end
                        if (r_is_read)  r_reads  <= sat_inc(r_reads);
                        if (r_is_write) r_writes <= sat_inc(r_writes);
                        if (r_hit) r_hits <= sat_inc(r_hits);
                        else       r_misses <= sat_inc(r_misses);
                        if (r_wb ? (r_vic_valid && r_vic_dirty) : r_is_write) begin
                            r_mem_writes <= sat_inc(r_mem_writes);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready       = (r_state == S_IDLE);
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_hit        = r_resp_hit;
    assign bus.resp_err        = r_resp_err;
    assign bus.resp_evict      = r_resp_evict;
    assign bus.resp_wb         = r_resp_wb;
    assign bus.resp_evict_addr = r_resp_evict_addr;
    assign reads               = r_reads;
    assign writes              = r_writes;
    assign hits                = r_hits;
    assign misses              = r_misses;
    assign mem_writes          = r_mem_writes;
endmodule

// File: tb/tb_cache_level.sv
// Bench for cache_level: table of requests with expected responses through a scoreboard queue,
// plus hand sequences for counter saturation and reset in the middle of a request.
module tb_cache_level;
    localparam int AW = 48;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_X = 8'h41;

    typedef struct {
        logic          rst;
        logic [AW-1:0] addr;
        logic [7:0]    op;
        logic          rp;
        logic          wp;
        logic          hit;
        logic          err;
        logic          evict;
        logic          wb;
        logic [AW-1:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, rp, wp;
    logic [11:0] reads, writes, hits, misses, mem_writes;
    logic [3:0]  s_reads, s_writes, s_hits, s_misses, s_mem_writes;

    cache_level_if #(.ADDR_W(AW)) bus ();
    cache_level_if #(.ADDR_W(AW)) sbus ();

    cache_level #(.ADDR_W(AW), .NUM_SETS(16), .ASSOC(4), .BLOCK_BYTES(16), .CNT_W(12)) dut (
        .clk(clk), .reset(reset), .replace_policy(rp), .write_policy(wp), .bus(bus.slave),
        .reads(reads), .writes(writes), .hits(hits), .misses(misses), .mem_writes(mem_writes)
    );

    cache_level #(.ADDR_W(AW), .NUM_SETS(16), .ASSOC(4), .BLOCK_BYTES(16), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .replace_policy(rp), .write_policy(wp), .bus(sbus.slave),
        .reads(s_reads), .writes(s_writes), .hits(s_hits), .misses(s_misses), .mem_writes(s_mem_writes)
    );

    int   n_vec  = 0;
    int   n_fail = 0;
    int   m_reads, m_writes, m_hits, m_misses, m_mem_writes;
    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [AW-1:0] a, input logic [7:0] op, input logic p_r,
                       input logic p_w, input logic h, input logic e, input logic ev, input logic b,
                       input logic [AW-1:0] ea);
        vec_t v;
        v = '{rst: r, addr: a, op: op, rp: p_r, wp: p_w, hit: h, err: e, evict: ev, wb: b, eaddr: ea};
        vecs.push_back(v);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_reads"},      64'(reads),      64'(m_reads));
        chk({tag, "_writes"},     64'(writes),     64'(m_writes));
        chk({tag, "_hits"},       64'(hits),       64'(m_hits));
        chk({tag, "_misses"},     64'(misses),     64'(m_misses));
        chk({tag, "_mem_writes"}, 64'(mem_writes), 64'(m_mem_writes));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        sbus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_mem_writes = 0;
    endtask

    task automatic do_req(input vec_t v, input string tag);
        vec_t e;
        int   lat;
        logic got;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_op    = v.op;
        rp = v.rp;
        wp = v.wp;
        sb.push_back(v);
        @(posedge clk);
        #1;
        // Scramble everything after accept: the in-flight request must not see it
        bus.req_valid = 1'b0;
        bus.req_addr  = '1;
        bus.req_op    = 8'h00;
        rp = ~v.rp;
        wp = ~v.wp;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = bus.resp_valid;
        end
        e = sb.pop_front();
        chk({tag, "_resp_seen"}, 64'(got), 64'(1));
        if (got) begin
            chk({tag, "_latency"}, 64'(lat), 64'(3));
            chk({tag, "_ready_at_resp"}, 64'(bus.req_ready), 64'(1));
            chk({tag, "_hit"},   64'(bus.resp_hit),   64'(e.hit));
            chk({tag, "_err"},   64'(bus.resp_err),   64'(e.err));
            chk({tag, "_evict"}, 64'(bus.resp_evict), 64'(e.evict));
            chk({tag, "_wb"},    64'(bus.resp_wb),    64'(e.wb));
            if (e.evict) chk({tag, "_evict_addr"}, 64'(bus.resp_evict_addr), 64'(e.eaddr));
            if (!e.err) begin
                m_reads  += (e.op == OP_R) ? 1 : 0;
                m_writes += (e.op == OP_W) ? 1 : 0;
                m_hits   += e.hit ? 1 : 0;
                m_misses += e.hit ? 0 : 1;
                m_mem_writes += e.wp ? (e.wb ? 1 : 0) : ((e.op == OP_W) ? 1 : 0);
            end
            check_counters(tag);
            @(negedge clk);
            chk({tag, "_pulse_one_cycle"}, 64'(bus.resp_valid), 64'(0));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        int   lat;
        logic got;

        // rst, addr, op, rp, wp, hit, err, evict, wb, evict_addr
        add(1'b1, 48'h0000006324d8, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h0000006324d8, OP_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        // LRU: the 0x000 hit protects it, 0x100 is evicted
        add(1'b1, 48'h000, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h100, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h200, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h300, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h000, OP_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h400, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'h100);
        // FIFO: hits leave ages alone
        add(1'b1, 48'h000, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h100, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h200, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h300, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h000, OP_R, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h400, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'h000);
        add(1'b0, 48'h100, OP_R, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h000, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'h100);
        // Write-back LRU: dirty fill, clean fills, dirty write hit
        add(1'b1, 48'h000, OP_W, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h100, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h200, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h300, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h400, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 48'h000);
        add(1'b0, 48'h000, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 48'h100);
        add(1'b0, 48'h200, OP_W, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h500, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 48'h300);
        add(1'b0, 48'h600, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 48'h400);
        add(1'b0, 48'h700, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 48'h000);
        add(1'b0, 48'h800, OP_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 48'h200);
        // Write-through: every write goes to memory
        add(1'b1, 48'h7fff493822b8, OP_W, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h7fff493822b8, OP_W, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h7fff493822b8, OP_W, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        // Invalid op: error only, no allocation, no counting
        add(1'b0, 48'h7fff493822b8, OP_X, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h7fff493822b8, OP_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h000000001230, OP_X, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0);
        add(1'b0, 48'h000000001230, OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);

        reset = 1'b1;
        rp = 1'b0;
        wp = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_op     = 8'h00;
        sbus.req_valid = 1'b0;
        sbus.req_addr  = '0;
        sbus.req_op    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_mem_writes = 0;

        @(negedge clk);
        chk("reset_req_ready",  64'(bus.req_ready),  64'(1));
        chk("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("reset_resp_hit",   64'(bus.resp_hit),   64'(0));
        check_counters("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Saturation on the 4-bit-counter instance: 20 reads of one line
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sbus.req_valid = 1'b1;
            sbus.req_addr  = 48'h40;
            sbus.req_op    = OP_R;
            @(posedge clk);
            #1;
            sbus.req_valid = 1'b0;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 10) begin
                @(negedge clk);
                lat++;
                got = sbus.resp_valid;
            end
            if (!got) chk("sat_resp_seen", 64'(got), 64'(1));
        end
        @(negedge clk);
        chk("sat_reads",  64'(s_reads),  64'(15));
        chk("sat_hits",   64'(s_hits),   64'(15));
        chk("sat_misses", 64'(s_misses), 64'(1));
        chk("sat_writes", 64'(s_writes), 64'(0));

        // Reset while a request sits in LOOKUP
        do_reset();
        do_req(vecs[2], "pre_abort");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 48'h000;
        bus.req_op    = OP_R;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_mem_writes = 0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | bus.resp_valid;
        end
        chk("abort_no_resp",     64'(seen),            64'(0));
        chk("abort_req_ready",   64'(bus.req_ready),   64'(1));
        chk("abort_resp_err",    64'(bus.resp_err),    64'(0));
        chk("abort_resp_evict",  64'(bus.resp_evict),  64'(0));
        chk("abort_resp_wb",     64'(bus.resp_wb),     64'(0));
        check_counters("abort");
        do_req(vecs[2], "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
